// File: rtl/rsa_bit_packer_if.sv
// Byte-in / block-out handshake bundle for rsa_bit_packer.
// The master view is the packer itself; the slave view is the surrounding UART and RSA logic.
interface rsa_bit_packer_if #(
    parameter int KEY_W  = 32,
    parameter int DATA_W = 8
);
    logic              ready_in;
    logic              eot_in;
    logic [DATA_W-1:0] data_in;
    logic              clear_rx_flag;
    logic              word_valid;
    logic              word_ready;
    logic [KEY_W-1:0]  word_out;
    logic              word_last;

    modport master (
        input  ready_in, eot_in, data_in, word_ready,
        output clear_rx_flag, word_valid, word_out, word_last
    );

    modport slave (
        output ready_in, eot_in, data_in, word_ready,
        input  clear_rx_flag, word_valid, word_out, word_last
    );
endinterface

// File: rtl/rsa_bit_packer.sv
// Repacks a received symbol stream, MSB first, into blocks of floor(log2(n_key)) bits for the RSA core.
// End-of-text flushes any residue as a zero-padded final block.
module rsa_bit_packer #(
    parameter int KEY_W  = 32,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [KEY_W-1:0]         n_key,
    rsa_bit_packer_if.master         bus,
    output logic [$clog2(KEY_W)-1:0] chunk_w,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam int BUF_W = KEY_W + DATA_W;
    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam int CW_W  = $clog2(KEY_W);
    localparam logic [BUF_W-1:0] BUF_ONE = BUF_W'(1);
    localparam logic [KEY_W-1:0] KEY_ONE = KEY_W'(1);

    typedef enum logic [2:0] {IDLE, SETUP, COLLECT, EMIT, FLUSH, DONE} state_t;

    state_t            state, state_nxt;
    logic [KEY_W-1:0]  key_q;
    logic [BUF_W-1:0]  bits_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CW_W-1:0]   chunk_q;
    logic [CW_W-1:0]   msb_idx;
    logic              clr_q;
    logic              err_q;

    logic              key_bad;
    logic              have_block;
    logic              accept;
    logic [CNT_W-1:0]  chunk_ext;
    logic [CNT_W-1:0]  tail_cnt;
    logic [KEY_W-1:0]  word_mask;
    logic [KEY_W-1:0]  head_word;
    logic [KEY_W-1:0]  flush_word;

    // The buffer keeps its cnt_q valid bits right-aligned; older bits sit higher.
    assign key_bad    = n_key < KEY_W'(2);
    assign chunk_ext  = CNT_W'(chunk_q);
    assign have_block = cnt_q >= chunk_ext;
    assign tail_cnt   = cnt_q - chunk_ext;
    assign word_mask  = (KEY_ONE << chunk_q) - KEY_ONE;
    assign head_word  = KEY_W'(bits_q >> tail_cnt) & word_mask;
    assign flush_word = KEY_W'(bits_q << (chunk_ext - cnt_q)) & word_mask;

    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < KEY_W; i++) begin
            if (key_q[i]) msb_idx = CW_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_nxt      = state;
        accept         = 1'b0;
        bus.word_valid = 1'b0;
        bus.word_out   = '0;
        bus.word_last  = 1'b0;
        done           = 1'b0;
        case (state)
            IDLE:    if (start && !key_bad) state_nxt = SETUP;
            SETUP:   state_nxt = COLLECT;
            COLLECT: begin
                if (have_block) begin
                    state_nxt = EMIT;
                end else if (bus.ready_in && !clr_q) begin
                    accept = 1'b1;
                    if (bus.eot_in) state_nxt = FLUSH;
                end
            end
            EMIT: begin
                bus.word_valid = 1'b1;
                bus.word_out   = head_word;
                if (bus.word_ready) state_nxt = COLLECT;
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_nxt = DONE;
                end else begin
                    bus.word_valid = 1'b1;
                    bus.word_last  = 1'b1;
                    bus.word_out   = flush_word;
                    if (bus.word_ready) state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            key_q   <= '0;
            bits_q  <= '0;
            cnt_q   <= '0;
            chunk_q <= '0;
            clr_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            clr_q <= accept;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (key_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q <= 1'b0;
                            key_q <= n_key;
                        end
                    end
                end
                SETUP: begin
                    chunk_q <= msb_idx;
                    bits_q  <= '0;
                    cnt_q   <= '0;
                end
                COLLECT: begin
                    if (accept && !bus.eot_in) begin
                        bits_q <= {bits_q[BUF_W-DATA_W-1:0], bus.data_in};
                        cnt_q  <= cnt_q + CNT_W'(DATA_W);
                    end
                end
                EMIT: begin
                    if (bus.word_ready) begin
                        bits_q <= bits_q & ((BUF_ONE << tail_cnt) - BUF_ONE);
                        cnt_q  <= tail_cnt;
                    end
                end
                FLUSH: begin
                    if (bus.word_ready || cnt_q == '0) begin
                        bits_q <= '0;
                        cnt_q  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.clear_rx_flag = clr_q;
    assign chunk_w           = chunk_q;
    assign err               = err_q;
    assign busy              = state != IDLE;
endmodule

// File: tb/tb_rsa_bit_packer.sv
// Directed bench for rsa_bit_packer: a bit-queue model predicts every block, and a per-cycle
// compare process checks the DUT against it, with literal values pinning the model.
module tb_rsa_bit_packer;
    localparam int KEY_W  = 32;
    localparam int DATA_W = 8;

    typedef struct {
        logic [KEY_W-1:0] word;
        logic             last;
    } blk_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [KEY_W-1:0] n_key = '0;
    logic [4:0]       chunk_w;
    logic             busy, done, err;

    rsa_bit_packer_if #(.KEY_W(KEY_W), .DATA_W(DATA_W)) bus ();

    rsa_bit_packer #(.KEY_W(KEY_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .n_key   (n_key),
        .bus     (bus),
        .chunk_w (chunk_w),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int clr_cnt = 0;
    int done_cnt = 0;

    blk_t             exp_q[$];
    logic [KEY_W-1:0] got_w[$];
    logic             got_l[$];
    bit               mbits[$];
    int               m_chunk = 1;

    logic [7:0] msg_a[7] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77};
    logic [7:0] msg_d[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Block width is the largest w with 2**w <= n, i.e. the bit length of n minus one.
    function automatic int model_chunk(input longint n);
        return $clog2(n + 1) - 1;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        blk_t e;
        for (int i = 7; i >= 0; i--) mbits.push_back(b[i]);
        while (mbits.size() >= m_chunk) begin
            e.word = '0;
            e.last = 1'b0;
            for (int i = 0; i < m_chunk; i++) e.word = {e.word[KEY_W-2:0], mbits.pop_front()};
            exp_q.push_back(e);
        end
    endfunction

    function automatic void model_eot();
        blk_t e;
        bit   b;
        if (mbits.size() > 0) begin
            e.word = '0;
            e.last = 1'b1;
            for (int i = 0; i < m_chunk; i++) begin
                b = (mbits.size() > 0) ? mbits.pop_front() : 1'b0;
                e.word = {e.word[KEY_W-2:0], b};
            end
            exp_q.push_back(e);
        end
        mbits.delete();
    endfunction

    always @(negedge clk) begin
        if (rst && bus.word_valid) begin
            check("block_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                check("word_out", bus.word_out, exp_q[0].word);
                check("word_last", bus.word_last, exp_q[0].last);
                if (bus.word_ready) begin
                    got_w.push_back(bus.word_out);
                    got_l.push_back(bus.word_last);
                    exp_q.delete(0);
                end
            end
        end
        if (bus.clear_rx_flag) clr_cnt++;
        if (done) done_cnt++;
    end

    task automatic start_session(input logic [KEY_W-1:0] n);
        @(negedge clk);
        n_key = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (n >= 2) begin
            m_chunk = model_chunk(longint'(n));
            mbits.delete();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit eot);
        bit ok = 1'b0;
        @(negedge clk);
        bus.data_in  = b;
        bus.eot_in   = eot;
        bus.ready_in = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (bus.clear_rx_flag) ok = 1'b1;
        end
        bus.ready_in = 1'b0;
        bus.eot_in   = 1'b0;
        check("byte_accepted", ok, 1);
        if (ok) begin
            if (eot) model_eot();
            else     model_byte(b);
        end
    endtask

    task automatic wait_done(input string name);
        int d0 = done_cnt;
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk);
            if (done_cnt > d0) ok = 1'b1;
        end
        check(name, ok, 1);
    endtask

    task automatic wait_valid(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (bus.word_valid) ok = 1'b1;
        end
        check(name, ok, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clear"}, bus.clear_rx_flag, 0);
        check({tag, "_valid"}, bus.word_valid, 0);
        check({tag, "_word"},  bus.word_out, 0);
        check({tag, "_last"},  bus.word_last, 0);
        check({tag, "_chunk"}, chunk_w, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_err"},   err, 0);
    endtask

    initial begin
        int               g0, c0, d0, lat;
        logic [KEY_W-1:0] held;
        bit               ok;

        bus.ready_in   = 1'b0;
        bus.eot_in     = 1'b0;
        bus.data_in    = '0;
        bus.word_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Degenerate modulus flags an error and never starts a session.
        start_session(32'd1);
        check("err_set", err, 1);
        check("err_not_busy", busy, 0);
        @(negedge clk);
        check("err_still_idle", busy, 0);

        // Reference message: two full blocks and a padded final block.
        start_session(32'd96022049);
        check("err_cleared", err, 0);
        check("busy_in_setup", busy, 1);
        @(negedge clk);
        check("chunk_model", chunk_w, m_chunk);
        check("chunk_lit", chunk_w, 26);
        check("busy_collect", busy, 1);
        bus.word_ready = 1'b1;
        g0 = got_w.size();
        c0 = clr_cnt;
        d0 = done_cnt;
        foreach (msg_a[i]) send_byte(msg_a[i], 1'b0);
        send_byte(8'h04, 1'b1);
        wait_done("a_done");
        repeat (3) @(negedge clk);
        check("a_blocks", got_w.size() - g0, 3);
        if (got_w.size() >= g0 + 3) begin
            check("a_blk0_lit", got_w[g0], 32'h1A195B1);
            check("a_blk1_lit", got_w[g0+1], 32'h2C6F207);
            check("a_blk2_lit", got_w[g0+2], 32'h1C00000);
            check("a_blk0_last", got_l[g0], 0);
            check("a_blk2_last", got_l[g0+2], 1);
        end
        check("a_clear_pulses", clr_cnt - c0, 8);
        check("a_done_pulses", done_cnt - d0, 1);
        check("a_exp_empty", exp_q.size(), 0);
        check("a_idle", busy, 0);

        // EOT with an empty buffer: no final block, only done.
        start_session(32'h0001_0001);
        g0 = got_w.size();
        d0 = done_cnt;
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h00, 1'b1);
        wait_done("b_done");
        repeat (3) @(negedge clk);
        check("b_blocks", got_w.size() - g0, 1);
        if (got_w.size() >= g0 + 1) begin
            check("b_blk_lit", got_w[g0], 32'h1234);
            check("b_blk_last", got_l[g0], 0);
        end
        check("b_done_pulses", done_cnt - d0, 1);

        // Narrowest practical block width: 9 bits from 8-bit symbols.
        start_session(32'd1000);
        c0 = clr_cnt;
        for (int i = 1; i <= 10; i++) send_byte(8'(i * 37), 1'b0);
        send_byte(8'h04, 1'b1);
        wait_done("c_done");
        repeat (2) @(negedge clk);
        check("c_clear_pulses", clr_cnt - c0, 11);
        check("c_exp_empty", exp_q.size(), 0);

        // Backpressure: block held, pending symbol waits until release.
        start_session(32'hFFFF_FFFF);
        bus.word_ready = 1'b0;
        g0 = got_w.size();
        foreach (msg_d[i]) send_byte(msg_d[i], 1'b0);
        @(negedge clk);
        bus.data_in  = 8'hA5;
        bus.eot_in   = 1'b0;
        bus.ready_in = 1'b1;
        wait_valid("d_valid");
        held = bus.word_out;
        check("d_held_lit", held, 32'h6F56DF77);
        c0 = clr_cnt;
        repeat (50) begin
            @(posedge clk);
            #1;
            check("d_stable", bus.word_out, held);
            check("d_still_valid", bus.word_valid, 1);
            check("d_no_clear", bus.clear_rx_flag, 0);
        end
        check("d_clear_count", clr_cnt - c0, 0);
        bus.word_ready = 1'b1;
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.clear_rx_flag) ok = 1'b1;
        end
        bus.ready_in = 1'b0;
        check("d_pending_taken", ok, 1);
        check("d_pending_latency", lat <= 3, 1);
        if (ok) model_byte(8'hA5);
        send_byte(8'h04, 1'b1);
        wait_done("d_done");
        repeat (2) @(negedge clk);
        check("d_blocks", got_w.size() - g0, 2);
        if (got_w.size() >= g0 + 2) check("d_flush_lit", got_w[g0+1], 32'h6940_0000);
        check("d_exp_empty", exp_q.size(), 0);

        // Reset while a block is being offered, then a clean restart.
        start_session(32'd96022049);
        bus.word_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(msg_a[i], 1'b0);
        wait_valid("e_valid");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        mbits.delete();
        start_session(32'd96022049);
        bus.word_ready = 1'b1;
        g0 = got_w.size();
        for (int i = 0; i < 4; i++) send_byte(msg_a[i], 1'b0);
        send_byte(8'h04, 1'b1);
        wait_done("e_done");
        repeat (2) @(negedge clk);
        check("e_blocks", got_w.size() - g0, 2);
        if (got_w.size() >= g0 + 2) begin
            check("e_blk0_lit", got_w[g0], 32'h1A195B1);
            check("e_flush_lit", got_w[g0+1], 32'h2C00000);
            check("e_flush_last", got_l[g0+1], 1);
        end
        check("e_exp_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end
endmodule
